// File: rtl/wr_drain_ctrl.sv
// Per-bank write-occupancy tracker with a hysteresis read/write-drain mode FSM.
// Optional starvation timer that forces a drain is built only when WR_STARVE_EN is defined.
module wr_drain_ctrl #(
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned LOW_WM     = 2,
  parameter int unsigned HIGH_WM    = 12,
  parameter int unsigned STARVE_LIM = 64,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned TW = $clog2(NUM_BANKS * DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_BANKS-1:0]    wr_push,
  input  logic [NUM_BANKS-1:0]    wr_pop,
  input  logic                    rd_pending,
  output logic                    wr_mode,
  output logic                    lwm,
  output logic                    hwm,
  output logic [NUM_BANKS*CW-1:0] bank_cnt,
  output logic [NUM_BANKS-1:0]    bank_nonempty,
  output logic [TW-1:0]           total,
  output logic                    err_ovf,
  output logic                    err_udf
);

  typedef enum logic [0:0] {StRead, StDrain} state_e;

  // Elaboration-time parameter sanity checks.
  if (HIGH_WM <= LOW_WM || HIGH_WM > NUM_BANKS * DEPTH) begin : g_bad_wm
    $error("wr_drain_ctrl: watermark parameters out of range");
  end
  if (STARVE_LIM < 2) begin : g_bad_starve
    $error("wr_drain_ctrl: STARVE_LIM must be at least 2");
  end

  logic [CW-1:0]        cnt_q [NUM_BANKS];
  logic [CW-1:0]        cnt_d [NUM_BANKS];
  logic [NUM_BANKS-1:0] inc, dec, ovf_hit, udf_hit;
  logic [TW-1:0]        total_q, total_d, inc_sum, dec_sum;
  logic                 err_ovf_q, err_udf_q;
  state_e               state_q, state_d;
  logic                 starve_hit;

  // Per-bank effective deltas; blocked push/pop only raise the error flags.
  always_comb begin
    inc     = '0;
    dec     = '0;
    ovf_hit = '0;
    udf_hit = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      cnt_d[b] = cnt_q[b];
      if (wr_push[b] && !wr_pop[b]) begin
        if (cnt_q[b] == CW'(DEPTH)) begin
          ovf_hit[b] = 1'b1;
        end else begin
          inc[b]   = 1'b1;
          cnt_d[b] = cnt_q[b] + CW'(1);
        end
      end else if (wr_pop[b] && !wr_push[b]) begin
        if (cnt_q[b] == '0) begin
          udf_hit[b] = 1'b1;
        end else begin
          dec[b]   = 1'b1;
          cnt_d[b] = cnt_q[b] - CW'(1);
        end
      end
    end
  end

  always_comb begin
    inc_sum = '0;
    dec_sum = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      inc_sum = inc_sum + TW'(inc[b]);
      dec_sum = dec_sum + TW'(dec[b]);
    end
    total_d = total_q + inc_sum - dec_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        cnt_q[b] <= '0;
      end
      total_q   <= '0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
      total_q   <= total_d;
      err_ovf_q <= err_ovf_q | (|ovf_hit);
      err_udf_q <= err_udf_q | (|udf_hit);
    end
  end

  always_comb begin
    bank_cnt      = '0;
    bank_nonempty = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_cnt[b*CW +: CW] = cnt_q[b];
      bank_nonempty[b]     = |cnt_q[b];
    end
  end

  assign total   = total_q;
  assign lwm     = (total_q <= TW'(LOW_WM));
  assign hwm     = (total_q >= TW'(HIGH_WM));
  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;

`ifdef WR_STARVE_EN
  localparam int unsigned SW = (STARVE_LIM > 2) ? $clog2(STARVE_LIM) : 1;

  logic [SW-1:0] timer_q, timer_d;

  assign starve_hit = (state_q == StRead) && (total_q != '0) &&
                      (timer_q == SW'(STARVE_LIM - 1));

  always_comb begin
    if (state_q == StDrain || total_q == '0 || starve_hit) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  // Hysteresis: once draining, keep going until the low watermark is reached with reads waiting.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRead: begin
        if (hwm || (!rd_pending && total_q != '0) || starve_hit) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (total_q == '0 || (lwm && rd_pending)) begin
          state_d = StRead;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRead;
    end else begin
      state_q <= state_d;
    end
  end

  assign wr_mode = (state_q == StDrain);

endmodule

// File: tb/tb_wr_drain_ctrl.sv
// Directed, table-driven bench for wr_drain_ctrl at default parameters.
// Define WR_STARVE_EN for both bench and RTL to exercise the starvation timer.
module tb_wr_drain_ctrl;

  localparam int LWM = 2;
  localparam int HWM = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  wr_push, wr_pop;
  logic        rd_pending;
  logic        wr_mode, lwm, hwm, err_ovf, err_udf;
  logic [19:0] bank_cnt;
  logic [3:0]  bank_nonempty;
  logic [6:0]  total;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0]  push;
    logic [3:0]  pop;
    logic        rd;
    logic [6:0]  e_total;
    logic [19:0] e_cnt;
    logic        e_mode;
    logic        e_ovf;
    logic        e_udf;
  } vec_t;

  vec_t vecs[$];

  wr_drain_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_push       (wr_push),
    .wr_pop        (wr_pop),
    .rd_pending    (rd_pending),
    .wr_mode       (wr_mode),
    .lwm           (lwm),
    .hwm           (hwm),
    .bank_cnt      (bank_cnt),
    .bank_nonempty (bank_nonempty),
    .total         (total),
    .err_ovf       (err_ovf),
    .err_udf       (err_udf)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic [3:0] p, input logic [3:0] q, input logic r,
                              input int t, input logic [19:0] c, input logic m,
                              input logic o, input logic u);
    vec_t v;
    v.push = p; v.pop = q; v.rd = r; v.e_total = 7'(t); v.e_cnt = c;
    v.e_mode = m; v.e_ovf = o; v.e_udf = u;
    vecs.push_back(v);
  endfunction

  task automatic step(input logic [3:0] p, input logic [3:0] q, input logic r);
    wr_push = p; wr_pop = q; rd_pending = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [6:0] et, input logic [19:0] ec,
                       input logic em, input logic eo, input logic eu);
    logic       el, eh;
    logic [3:0] ene;
    el = (int'(et) <= LWM);
    eh = (int'(et) >= HWM);
    for (int b = 0; b < 4; b++) ene[b] = (ec[b*5 +: 5] != 5'd0);
    vectors++;
    if (total !== et || bank_cnt !== ec || wr_mode !== em || lwm !== el || hwm !== eh ||
        bank_nonempty !== ene || err_ovf !== eo || err_udf !== eu) begin
      miscompares++;
      $display("FAIL %s: got total=%0d cnt=%h mode=%b lwm=%b hwm=%b ne=%b ovf=%b udf=%b; want total=%0d cnt=%h mode=%b lwm=%b hwm=%b ne=%b ovf=%b udf=%b",
               name, total, bank_cnt, wr_mode, lwm, hwm, bank_nonempty, err_ovf, err_udf,
               et, ec, em, el, eh, ene, eo, eu);
    end
  endtask

  initial begin
    int rise;
    int exp_rise;

    // Ramp bank 0 to the high watermark with reads waiting, then drain back to low watermark.
    for (int i = 1; i <= 12; i++) add(4'b0001, 4'b0000, 1'b1, i, 20'(i), 1'b0, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 1'b1, 12, 20'd12, 1'b1, 1'b0, 1'b0);
    for (int i = 11; i >= 2; i--) add(4'b0000, 4'b0001, 1'b1, i, 20'(i), 1'b1, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 1'b1, 2, 20'd2, 1'b0, 1'b0, 1'b0);
    // Opportunistic drain when reads go away, then low-watermark exit.
    add(4'b0001, 4'b0000, 1'b1, 3, 20'd3, 1'b0, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 1'b0, 3, 20'd3, 1'b1, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 1'b1, 3, 20'd3, 1'b1, 1'b0, 1'b0);
    add(4'b0000, 4'b0001, 1'b1, 2, 20'd2, 1'b1, 1'b0, 1'b0);
    add(4'b0000, 4'b0001, 1'b1, 1, 20'd1, 1'b0, 1'b0, 1'b0);
    add(4'b0000, 4'b0001, 1'b1, 0, 20'd0, 1'b0, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 1'b0, 0, 20'd0, 1'b0, 1'b0, 1'b0);
    // All-bank push with a simultaneous pop on bank 1.
    add(4'b0010, 4'b0000, 1'b1, 1, 20'h00020, 1'b0, 1'b0, 1'b0);
    add(4'b1111, 4'b0010, 1'b1, 4, 20'h08421, 1'b0, 1'b0, 1'b0);
    add(4'b0000, 4'b1111, 1'b1, 0, 20'h00000, 1'b0, 1'b0, 1'b0);
    // Fill bank 2, then overflow, push+pop at full, and underflow on empty bank 3.
    for (int j = 1; j <= 16; j++)
      add(4'b0100, 4'b0000, 1'b1, j, 20'(j) << 10, (j >= 13), 1'b0, 1'b0);
    add(4'b0100, 4'b0000, 1'b1, 16, 20'd16 << 10, 1'b1, 1'b1, 1'b0);
    add(4'b0100, 4'b0100, 1'b1, 16, 20'd16 << 10, 1'b1, 1'b1, 1'b0);
    add(4'b0000, 4'b1000, 1'b1, 16, 20'd16 << 10, 1'b1, 1'b1, 1'b1);
    for (int k = 1; k <= 16; k++)
      add(4'b0000, 4'b0100, 1'b1, 16 - k, 20'(16 - k) << 10, (k <= 14), 1'b1, 1'b1);

    wr_push = '0; wr_pop = '0; rd_pending = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("in_reset", 7'd0, 20'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (5) step(4'b0000, 4'b0000, 1'b0);
    check("idle_after_reset", 7'd0, 20'd0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < vecs.size(); n++) begin
      step(vecs[n].push, vecs[n].pop, vecs[n].rd);
      check($sformatf("vec%0d", n), vecs[n].e_total, vecs[n].e_cnt, vecs[n].e_mode,
            vecs[n].e_ovf, vecs[n].e_udf);
    end

    // One write held with reads always pending: only the starvation timer may force a drain.
`ifdef WR_STARVE_EN
    exp_rise = 65;
`else
    exp_rise = 0;
`endif
    rise = 0;
    step(4'b0001, 4'b0000, 1'b1);
    for (int c = 2; c <= 200; c++) begin
      step(4'b0000, 4'b0000, 1'b1);
      if (wr_mode && rise == 0) rise = c;
    end
    vectors++;
    if (rise != exp_rise) begin
      miscompares++;
      $display("FAIL starve_rise: got first drain at edge %0d, want %0d (0 = never)",
               rise, exp_rise);
    end
    step(4'b0000, 4'b0001, 1'b1);
    step(4'b0000, 4'b0000, 1'b1);
    check("starve_cleanup", 7'd0, 20'd0, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset between clock edges.
    step(4'b0011, 4'b0000, 1'b1);
    step(4'b0011, 4'b0000, 1'b1);
    check("pre_async", 7'd4, 20'h00042, 1'b0, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("async_rst", 7'd0, 20'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0000, 4'b0000, 1'b1);
    check("post_async", 7'd0, 20'd0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wr_drain_ctrl.md
# wr_drain_ctrl

Per-bank write-occupancy tracker and read/write mode arbiter for the front-end bank scheduler. It tracks outstanding writes in each of NUM_BANKS bank queues and maintains the total count. It drives low and high watermarks and runs a hysteresis FSM that decides when the scheduler drains writes and when it serves reads. It sits between the request-type demux and the bank scheduler arbiter, replacing the single-queue fixed-threshold write counter.

## Interface
Parameters:
- NUM_BANKS, 4, number of bank write queues tracked
- DEPTH, 16, write capacity per bank queue
- LOW_WM, 2, total-count low watermark (inclusive)
- HIGH_WM, 12, total-count high watermark (inclusive); HIGH_WM > LOW_WM and HIGH_WM <= NUM_BANKS*DEPTH
- STARVE_LIM, 64, cycles writes may wait in read mode before a forced drain (used only with WR_STARVE_EN)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_push  in  NUM_BANKS  bit b: one write accepted into bank b queue this cycle
- wr_pop  in  NUM_BANKS  bit b: one write from bank b issued to the back end this cycle
- rd_pending  in  1  at least one read waiting in any bank
- wr_mode  out  1  0 = READ_MODE, 1 = WRITE_DRAIN
- lwm  out  1  total <= LOW_WM
- hwm  out  1  total >= HIGH_WM
- bank_cnt  out  NUM_BANKS*$clog2(DEPTH+1)  packed per-bank counts, bank 0 in LSBs
- bank_nonempty  out  NUM_BANKS  bit b = (bank_cnt[b] != 0)
- total  out  $clog2(NUM_BANKS*DEPTH+1)  sum of bank counts
- err_ovf  out  1  sticky: push to a full bank
- err_udf  out  1  sticky: pop from an empty bank

## Operation
- Per bank b, per cycle:
  - push only: count +1.
  - pop only: count -1.
  - push and pop together: count unchanged, even when the count is 0 or DEPTH.
- Push only at count == DEPTH: ignored and err_ovf set. Pop only at count == 0: ignored and err_udf set. Neither error flag wraps a count.
- total is registered and always equals the sum of the registered bank counts. It updates in the same cycle as the bank counts, from the per-bank effective deltas.
- lwm, hwm and bank_nonempty are combinational from the registered counts.
- FSM, READ_MODE -> WRITE_DRAIN when any of the following holds:
  - hwm is set.
  - rd_pending == 0 and total != 0 (opportunistic drain).
  - The starvation timer expires (WR_STARVE_EN only).
- FSM, WRITE_DRAIN -> READ_MODE when either of the following holds:
  - total == 0.
  - lwm is set and rd_pending == 1.
- Staying in WRITE_DRAIN while LOW_WM < total < HIGH_WM gives the hysteresis.
- Err flags clear only on reset.

## Timing
- Reset (async assert, synchronous deassert on next clk edge):
  - all bank counts, total and timer are 0
  - wr_mode is 0
  - lwm is 1, hwm is 0, bank_nonempty is 0
  - err_ovf and err_udf are 0
- Counts, total and err flags reflect cycle-N inputs after edge N+1. lwm and hwm follow in the same cycle.
- wr_mode transitions are registered and evaluated on current registered counts and current rd_pending. A threshold crossing at edge N+1 changes wr_mode at edge N+2.
- Reset asserted mid-operation forces all state to reset values immediately, without waiting for clk.

## Configuration
- WR_STARVE_EN defined:
  - A starvation timer of width $clog2(STARVE_LIM) increments each cycle while wr_mode == 0 and total != 0.
  - The timer clears to 0 in WRITE_DRAIN or when total == 0.
  - When the timer equals STARVE_LIM-1, the FSM enters WRITE_DRAIN on the next edge and the timer clears.
- WR_STARVE_EN undefined:
  - No timer logic is built and STARVE_LIM is unused.
  - Writes can wait indefinitely while rd_pending stays 1 and total < HIGH_WM.

## Test plan
- Reset, then idle 5 cycles -> total=0, lwm=1, hwm=0, wr_mode=0, errors 0. Assert rst_n low asynchronously mid-count -> outputs return to these values without a clk edge.
- With rd_pending=1, push 12 writes to bank 0 on consecutive cycles:
  - After the 12th push, total=12 and hwm=1.
  - wr_mode=1 one cycle later.
  - Pop down to 2 -> wr_mode=0 one cycle after total=2.
- With total=5 in WRITE_DRAIN and rd_pending=1 -> wr_mode holds 1 (hysteresis). Drop rd_pending at total=3 in READ_MODE -> wr_mode=1 one cycle later.
- Bank 2 at DEPTH=16:
  - push -> count stays 16, err_ovf=1.
  - push+pop together -> count stays 16, no new error.
  - Pop from an empty bank 3 -> err_udf=1, count stays 0.
- Simultaneous push on all 4 banks plus pop on bank 1 (count 1) -> total net +3, bank 1 unchanged.
- With WR_STARVE_EN, rd_pending=1 and total=1 held -> wr_mode=1 at cycle 64 after the first write. Without WR_STARVE_EN -> wr_mode stays 0 for 200 cycles.
